// File: rtl/tru_nbit_ctrl.sv
// Nibble-serial WIDTH-bit subtract sequencer: drives one external 4-bit subtractor
// LSB nibble first and assembles D = A - B - bin with borrow, overflow and a start/done handshake.
module tru_nbit_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic [3:0]       sub_a,
    output logic [3:0]       sub_b,
    output logic             sub_bin,
    input  logic [3:0]       sub_d,
    input  logic             sub_bo
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               brw_q, brw_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         opa_nib [N];
    logic [3:0]         opb_nib [N];
    logic               last_step;

    assign last_step = (idx_q == IDX_W'(N - 1));

    // Nibble views of the operands, and per-nibble capture of the subtractor result.
    for (genvar gi = 0; gi < N; gi++) begin : g_nib
        assign opa_nib[gi] = opa_q[4*gi +: 4];
        assign opb_nib[gi] = opb_q[4*gi +: 4];
        assign res_d[4*gi +: 4] = (state_q == S_RUN && idx_q == IDX_W'(gi)) ? sub_d
                                                                            : res_q[4*gi +: 4];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        sub_a   = 4'd0;
        sub_b   = 4'd0;
        sub_bin = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    brw_d   = bin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                sub_a   = opa_nib[idx_q];
                sub_b   = opb_nib[idx_q];
                sub_bin = brw_q;
                brw_d   = sub_bo;
                if (last_step) begin
                    // Top nibble comes straight from the subtractor; lower nibbles are already captured.
                    d_d     = {sub_d, res_q[WIDTH-5:0]};
                    bo_d    = sub_bo;
                    ovf_d   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (sub_d[3] != opa_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d   = d_q;
    assign bo  = bo_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_tru_nbit_ctrl.sv
// Directed bench for tru_nbit_ctrl (WIDTH=16) with a behavioural 4-bit subtractor attached.
module tb_tru_nbit_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bo, ovf;
    logic [15:0] d;
    logic [3:0]  sub_a, sub_b, sub_d;
    logic        sub_bin, sub_bo;
    logic [4:0]  diff5;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] prev_d = '0;

    always #5 clk = ~clk;

    assign diff5  = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_bin};
    assign sub_d  = diff5[3:0];
    assign sub_bo = diff5[4];

    tru_nbit_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bo(bo), .ovf(ovf),
        .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
        .sub_d(sub_d), .sub_bo(sub_bo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation from an IDLE negedge; returns at the IDLE negedge after DONE.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                          input logic [15:0] ed, input logic ebo, input logic eovf,
                          input logic [15:0] esa, input logic [3:0] esbin, input bit hold);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            a = 16'hFFFF; b = 16'h0000; bin = 1'b0; start = 1'b1;
        end else begin
            start = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("run%0d_busy", k), {31'b0, busy}, 32'd1);
            chk($sformatf("run%0d_done", k), {31'b0, done}, 32'd0);
            chk($sformatf("run%0d_sub_a", k), {28'b0, sub_a}, {28'b0, esa[4*k +: 4]});
            chk($sformatf("run%0d_sub_bin", k), {31'b0, sub_bin}, {31'b0, esbin[k]});
            chk($sformatf("run%0d_d_held", k), {16'b0, d}, {16'b0, prev_d});
            @(posedge clk);
            @(negedge clk);
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd1);
        chk("done_sub_a_idle", {28'b0, sub_a}, 32'd0);
        chk("result_d", {16'b0, d}, {16'b0, ed});
        chk("result_bo", {31'b0, bo}, {31'b0, ebo});
        chk("result_ovf", {31'b0, ovf}, {31'b0, eovf});
        $display("op %h - %h bin=%0d -> d=%h bo=%0d ovf=%0d", ia, ib, ibin, d, bo, ovf);
        prev_d = ed;
        @(posedge clk);
        @(negedge clk);
        chk("after_done", {31'b0, done}, 32'd0);
        chk("after_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_d", {16'b0, d}, 32'd0);
        chk("rst_bo_ovf", {30'b0, bo, ovf}, 32'd0);
        chk("rst_sub", {23'b0, sub_a, sub_b, sub_bin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 16'h1234, 4'b0000, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 4'b1110, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 4'b1111, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 4'b1110, 1'b0);

        // Handshake: start/operand changes during RUN are ignored; held start re-accepted from IDLE
        run_op(16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0, 16'h00F0, 4'b0010, 1'b1);
        run_op(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 4'b0000, 1'b0);

        // Reset mid-operation
        a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_d", {16'b0, d}, 32'd0);
        chk("abort_bo_ovf", {30'b0, bo, ovf}, 32'd0);
        $display("reset mid-op -> busy=%0d done=%0d d=%h", busy, done, d);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone%0d", k), {31'b0, done}, 32'd0);
            if (k == 1) rst_n = 1'b1;
        end
        prev_d = 16'h0000;
        run_op(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 16'h0003, 4'b1110, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
